// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game datapath.
// Holds the playback state encoding, bus widths and the colour decode.
package simon_pkg;

   localparam int ADDR_W    = 4;
   localparam int VAL_W     = 2;
   localparam int N_DEFAULT = 10;

   typedef enum logic [2:0] {
      PLAY_IDLE,
      PLAY_FETCH,
      PLAY_SHOW,
      PLAY_GAP,
      PLAY_DONE
   } play_state_t;

   function automatic logic [3:0] val2onehot(input logic [VAL_W-1:0] v);
      return 4'b0001 << v;
   endfunction

endpackage

// File: rtl/play_timer.sv
// Loadable down-counter shared by the SHOW and GAP phases of playback.
// It reloads from value on load and saturates at zero.
module play_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= value;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/sequence_player.sv
// Simon playback engine: walks ROM entries 0..lvl-1, flashing one LED per entry,
// then pulses done. Owns the ROM read port while busy.
//
// state | meaning
// IDLE  | waiting for start, rd_addr parked at 0
// FETCH | ROM data for idx is on rd_data, captured into led on exit
// SHOW  | led lit for ON_TICKS cycles
// GAP   | led dark for OFF_TICKS cycles
// DONE  | one-cycle done pulse, busy still high
module sequence_player
   import simon_pkg::*;
#(
   parameter int N         = N_DEFAULT,
   parameter int ON_TICKS  = 4,
   parameter int OFF_TICKS = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [3:0]        level,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [VAL_W-1:0]  rd_data,
   output logic [3:0]        led,
   output logic              busy,
   output logic              done
);

   localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int CW        = $clog2(MAX_TICKS + 1);

   play_state_t       state;
   logic [3:0]        lvl;
   logic [3:0]        idx;
   logic [3:0]        level_clamped;
   logic              last;
   logic              timer_load;
   logic [CW-1:0]     timer_value;
   logic              timer_zero;

   assign level_clamped = (level > 4'(N)) ? 4'(N) : level;
   assign last          = (idx == lvl - 4'd1);

   // The timer is reloaded on the edges that enter SHOW and GAP.
   assign timer_load  = (state == PLAY_FETCH) || (state == PLAY_SHOW && timer_zero);
   assign timer_value = (state == PLAY_FETCH) ? CW'(ON_TICKS - 1) : CW'(OFF_TICKS - 1);

   play_timer #(.W(CW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .zero  (timer_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= PLAY_IDLE;
         lvl     <= '0;
         idx     <= '0;
         rd_addr <= '0;
         led     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            PLAY_IDLE: begin
               led     <= '0;
               rd_addr <= '0;
               if (start) begin
                  lvl  <= level_clamped;
                  idx  <= '0;
                  busy <= 1'b1;
                  if (level_clamped == '0) begin
                     state <= PLAY_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= PLAY_FETCH;
                  end
               end
            end
            PLAY_FETCH: begin
               led   <= val2onehot(rd_data);
               state <= PLAY_SHOW;
            end
            PLAY_SHOW: begin
               if (timer_zero) begin
                  led   <= '0;
                  state <= PLAY_GAP;
                  // Present the next address early so the synchronous ROM
                  // has its data ready by the following FETCH cycle.
                  if (!last)
                     rd_addr <= idx + 4'd1;
               end
            end
            PLAY_GAP: begin
               if (timer_zero) begin
                  if (last) begin
                     state <= PLAY_DONE;
                     done  <= 1'b1;
                  end else begin
                     idx   <= idx + 4'd1;
                     state <= PLAY_FETCH;
                  end
               end
            end
            PLAY_DONE: begin
               busy    <= 1'b0;
               rd_addr <= '0;
               state   <= PLAY_IDLE;
            end
            default: state <= PLAY_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with a one-cycle-latency behavioural ROM.
module tb_sequence_player;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int P   = 1 + ON + OFF;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [3:0] level;
   logic [3:0] rd_addr;
   logic [1:0] rd_data;
   logic [3:0] led;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   logic [1:0] rom [16];

   sequence_player #(.N(10), .ON_TICKS(ON), .OFF_TICKS(OFF)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .level   (level),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .led     (led),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rd_data <= rom[rd_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Starts a playback at the next edge and checks every cycle through one idle
   // cycle after done. With disturb set, start is re-pulsed and level changed
   // during the first SHOW.
   task automatic play(input logic [3:0] lvl_in, input int nplay, input bit disturb);
      int         k;
      int         ph;
      logic [3:0] exp_led;
      start = 1'b1;
      level = lvl_in;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= nplay * P + 2; c++) begin
         @(negedge clk);
         k  = (c - 1) / P;
         ph = (c - 1) % P;
         exp_led = (k < nplay && ph >= 1 && ph <= ON) ? (4'b0001 << rom[k]) : 4'b0000;
         check($sformatf("led L%0d c%0d", lvl_in, c), 32'(led), 32'(exp_led));
         check($sformatf("done L%0d c%0d", lvl_in, c), 32'(done), 32'(c == nplay * P + 1));
         check($sformatf("busy L%0d c%0d", lvl_in, c), 32'(busy), 32'(c <= nplay * P + 1));
         if (k < nplay && ph == 0)
            check($sformatf("addr L%0d c%0d", lvl_in, c), 32'(rd_addr), 32'(k));
         if (disturb && c == 3) begin
            start = 1'b1;
            level = 4'd9;
         end
         if (disturb && c == 4)
            start = 1'b0;
      end
   endtask

   initial begin
      logic [1:0] init [10] = '{2'd2, 2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3, 2'd2};
      for (int i = 0; i < 16; i++) rom[i] = (i < 10) ? init[i] : 2'd0;
      reset = 1'b1;
      start = 1'b0;
      level = 4'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("idle led", 32'(led), 32'd0);
         check("idle addr", 32'(rd_addr), 32'd0);
         check("idle busy", 32'(busy), 32'd0);
         check("idle done", 32'(done), 32'd0);
      end

      // Three entries {2,0,3}: lit 0100 at t+2..5, 0001 at t+9..12, 1000 at t+16..19, done t+22
      play(4'd3, 3, 1'b0);
      // Zero-length round: done at t+1 only
      play(4'd0, 0, 1'b0);
      // Clamped to 10 entries, done at t+71
      play(4'd12, 10, 1'b0);
      // Disturbance during SHOW must not change a 2-entry playback
      play(4'd2, 2, 1'b1);

      // Reset during the second SHOW
      @(negedge clk);
      start = 1'b1;
      level = 4'd3;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      check("pre-reset led", 32'(led), 32'b0001);
      reset = 1'b1;
      @(negedge clk);
      check("rst led", 32'(led), 32'd0);
      check("rst addr", 32'(rd_addr), 32'd0);
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post-rst done", 32'(done), 32'd0);
         check("post-rst busy", 32'(busy), 32'd0);
      end
      play(4'd1, 1, 1'b0);

      // Reset wins over start
      reset = 1'b1;
      start = 1'b1;
      level = 4'd2;
      @(negedge clk);
      check("rst+start busy", 32'(busy), 32'd0);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check("rst+start idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
